// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: widths, per-step shift tables, FSM encoding.
// Latency: none (declarations and a combinational helper only).
// Backpressure: not applicable.
package des_pkg;

    localparam int KEY_W = 64;
    localparam int CD_W  = 28;
    localparam int SK_W  = 48;

    // Rotation amount per schedule step 1..16 (index 0 = step 1).
    // Encrypt rotates left; decrypt walks the same path backwards with right rotates.
    localparam logic [1:0] ENC_SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };
    localparam logic [1:0] DEC_SHIFT [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Rotate one 28-bit half; DES bit 1 sits in the MSB, so "left" moves bits toward the MSB.
    function automatic logic [CD_W-1:0] rot_cd(input logic [CD_W-1:0] x,
                                               input logic [1:0]      amt,
                                               input logic            right);
        logic [2*CD_W-1:0] w_dbl;
        logic [CD_W-1:0]   w_res;
        w_dbl = '0;
        w_res = '0;
        if (right) begin
            w_dbl = {x, x} >> amt;
            w_res = w_dbl[CD_W-1:0];
        end else begin
            w_dbl = {x, x} << amt;
            w_res = w_dbl[2*CD_W-1:CD_W];
        end
        return w_res;
    endfunction

endpackage

// File: rtl/des_pc1.sv
// DES Permuted Choice 1: 64-bit key -> 56-bit C||D, parity bits dropped.
// Latency: purely combinational.
// Backpressure: not applicable.
module des_pc1
    import des_pkg::*;
(
    input  logic [KEY_W-1:0]  i_key,
    output logic [2*CD_W-1:0] o_cd
);

    // Source DES bit number for each output bit 1..56 (DES bit n lives at vector index W-n).
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    for (genvar j = 0; j < 56; j++) begin : g_bit
        assign o_cd[2*CD_W-1-j] = i_key[KEY_W-PC1_TAB[j]];
    end

    // Parity bits 8,16,...,64 take no part in the schedule.
    logic w_unused_parity;
    assign w_unused_parity = ^{i_key[56], i_key[48], i_key[40], i_key[32],
                               i_key[24], i_key[16], i_key[8],  i_key[0]};

endmodule

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: 56-bit C||D -> 48-bit round subkey.
// Latency: purely combinational.
// Backpressure: not applicable.
module des_pc2
    import des_pkg::*;
(
    input  logic [2*CD_W-1:0] i_cd,
    output logic [SK_W-1:0]   o_sk
);

    // Source bit number (1..56 of C||D) for each subkey bit 1..48.
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    for (genvar j = 0; j < 48; j++) begin : g_bit
        assign o_sk[SK_W-1-j] = i_cd[2*CD_W-PC2_TAB[j]];
    end

    // C||D bits 9,18,22,25,35,38,43,54 are dropped by PC-2.
    logic w_unused_drop;
    assign w_unused_drop = ^{i_cd[47], i_cd[38], i_cd[34], i_cd[31],
                             i_cd[21], i_cd[18], i_cd[13], i_cd[2]};

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: streams the 16 round subkeys in encrypt (K1..K16) or decrypt (K16..K1) order.
// Latency: first subkey valid 1 cycle after start is accepted; one subkey per accepted transfer.
// Backpressure: valid/ready; without a transfer C/D, subkey and sk_num hold; done pulses after K16/K1 is taken.
module des_key_schedule
    import des_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key,      // DES bit 1 at key[63]
    input  logic             mode,     // 0 = encrypt order, 1 = decrypt order
    input  logic             sk_ready,
    output logic [SK_W-1:0]  subkey,   // DES bit 1 at subkey[47]
    output logic             sk_valid,
    output logic [4:0]       sk_num,
    output logic             busy,
    output logic             done
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CD_W-1:0] r_c;
    logic [CD_W-1:0] r_d;
    logic [4:0]      r_cnt;
    logic            r_mode;

    logic [2*CD_W-1:0] w_pc1;
    logic [CD_W-1:0]   w_c0;
    logic [CD_W-1:0]   w_d0;
    logic [1:0]        w_load_amt;
    logic [1:0]        w_step_amt;
    logic              w_load;
    logic              w_adv;

    des_pc1 u_pc1 (
        .i_key (key),
        .o_cd  (w_pc1)
    );

    des_pc2 u_pc2 (
        .i_cd  ({r_c, r_d}),
        .o_sk  (subkey)
    );

    assign w_c0 = w_pc1[2*CD_W-1:CD_W];
    assign w_d0 = w_pc1[CD_W-1:0];

    // Step 1 is applied on load; on advance from count n the next step is n+1 (table index n).
    assign w_load_amt = mode   ? DEC_SHIFT[0]          : ENC_SHIFT[0];
    assign w_step_amt = r_mode ? DEC_SHIFT[r_cnt[3:0]] : ENC_SHIFT[r_cnt[3:0]];

    assign sk_num = r_mode ? (5'd17 - r_cnt) : r_cnt;

    // Next-state decode and handshake/status outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        sk_valid    = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                sk_valid = 1'b1;
                if (sk_ready) begin
                    if (r_cnt == 5'd16) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus C/D halves, delivery count and latched order; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_c    <= rot_cd(w_c0, w_load_amt, mode);
                r_d    <= rot_cd(w_d0, w_load_amt, mode);
                r_cnt  <= 5'd1;
                r_mode <= mode;
            end else if (w_adv) begin
                r_c   <= rot_cd(r_c, w_step_amt, r_mode);
                r_d   <= rot_cd(r_d, w_step_amt, r_mode);
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

endmodule
